// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, FSM state encoding and a STATUS word packing helper.
// No logic; imported by mmio_uart_tx.
package mmio_uart_tx_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [31:0] TXDATA_OFF = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFF = 32'h0000_0004;

  // STATUS bit positions
  localparam int STAT_FULL   = 0;
  localparam int STAT_EMPTY  = 1;
  localparam int STAT_ACTIVE = 2;
  localparam int STAT_OVF    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [31:0] pack_status(input logic ovf, input logic active,
                                              input logic empty, input logic full);
    logic [31:0] w;
    w              = 32'b0;
    w[STAT_OVF]    = ovf;
    w[STAT_ACTIVE] = active;
    w[STAT_EMPTY]  = empty;
    w[STAT_FULL]   = full;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with first-word-fallthrough read (dout shows the head).
// Latency: a push is visible on dout/empty right after its clock edge.
// Backpressure: push on full is ignored unless a pop happens in the same cycle;
// pop on empty is ignored.
// Ports: CLK, RST (async active-high), push/din, pop/dout, full, empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // A pop frees the slot in the same cycle, so a push on full is still taken.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter fed by CPU stores to TXDATA, status polled via RdAddr.
// Latency: store at edge N queues the byte; start bit drives TX from edge N+1; frame = 10 bit periods.
// Backpressure: none toward the CPU; stores to a full FIFO are dropped and flag sticky Overflow.
// Ports: CLK, RST (async active-high); ALUResult/WriteData/MemWrite store port;
// RdAddr -> RdData combinational status read; TX serial line, Busy, Overflow.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic [31:0] RdAddr,
  output logic [31:0] RdData,
  output logic        TX,
  output logic        Busy,
  output logic        Overflow
);

  localparam int              CNT_W       = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0]     TXDATA_ADDR = BASE_ADDR + TXDATA_OFF;
  localparam logic [31:0]     STATUS_ADDR = BASE_ADDR + STATUS_OFF;

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d;

  logic             push_req;
  logic             ovf_clr;
  logic             ovf_set;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic             unused_wdata;

  assign unused_wdata = ^{WriteData[31:8], WriteData[7:0]};

  // Address decode on the store path
  assign push_req = MemWrite && (ALUResult == TXDATA_ADDR);
  assign ovf_clr  = MemWrite && (ALUResult == STATUS_ADDR) && WriteData[STAT_OVF];
  assign ovf_set  = push_req && fifo_full && !fifo_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (WriteData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Overflow <= 1'b0;
    end else if (ovf_set) begin
      Overflow <= 1'b1;
    end else if (ovf_clr) begin
      Overflow <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      TX      <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      TX      <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = CNT_RELOAD;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_RELOAD;
          idx_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {1'b0, shift_q[7:1]};
          cnt_d   = CNT_RELOAD;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            cnt_d    = CNT_RELOAD;
            state_d  = ST_START;
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // TX is registered from the next state so the line changes only on clock edges.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign Busy = (state_q != ST_IDLE) || !fifo_empty;

  always_comb begin
    RdData = 32'b0;
    if (RdAddr == STATUS_ADDR) begin
      RdData = pack_status(Overflow, state_q != ST_IDLE, fifo_empty, fifo_full);
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=0x1000.
// Inputs change and outputs are sampled on the falling clock edge.
// A background receiver decodes TX into a byte queue for ordering checks.
module tb_mmio_uart_tx;

  localparam int CPB = 4;

  logic        CLK;
  logic        RST;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic [31:0] RdAddr;
  logic [31:0] RdData;
  logic        TX;
  logic        Busy;
  logic        Overflow;

  int tests  = 0;
  int failed = 0;

  mmio_uart_tx #(
    .BASE_ADDR    (32'h0000_1000),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .RdAddr    (RdAddr),
    .RdData    (RdData),
    .TX        (TX),
    .Busy      (Busy),
    .Overflow  (Overflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Background receiver: bit 8 of each entry flags a bad stop bit.
  logic [8:0] rx_q[$];
  bit         rx_active = 1'b0;
  int         rx_c      = 0;
  logic [7:0] rx_sh     = '0;

  always @(negedge CLK) begin
    if (RST) begin
      rx_active = 1'b0;
      rx_c      = 0;
    end else if (!rx_active) begin
      if (TX === 1'b0) begin
        rx_active = 1'b1;
        rx_c      = 0;
      end
    end else begin
      rx_c++;
      if (rx_c >= 6 && rx_c <= 34 && ((rx_c - 6) % 4) == 0) rx_sh = {TX, rx_sh[7:1]};
      if (rx_c == 38) rx_q.push_back({~TX, rx_sh});
      if (rx_c == 39) rx_active = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive a store at the current falling edge; it takes effect at the next rising edge.
  task automatic set_store(input logic [31:0] addr, input logic [31:0] data);
    ALUResult = addr;
    WriteData = data;
    MemWrite  = 1'b1;
  endtask

  // Samples TX on each of the next 40 falling edges and compares against one 8N1 frame.
  task automatic expect_frame(input logic [7:0] d, input string name);
    logic [9:0] exp10;
    logic [9:0] got10;
    int         unstable;
    exp10    = {1'b1, d, 1'b0};
    got10    = '0;
    unstable = 0;
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge CLK);
      MemWrite = 1'b0;
      if ((k % CPB) == 0) got10[k / CPB] = TX;
      else if (TX !== got10[k / CPB]) unstable++;
    end
    check({name, "_bits"}, 32'(got10), 32'(exp10));
    check({name, "_stable"}, 32'(unstable), 32'd0);
  endtask

  task automatic wait_rx(input int n, input int limit);
    int c;
    c = 0;
    while (rx_q.size() < n && c < limit) begin
      @(negedge CLK);
      c++;
    end
  endtask

  task automatic wait_idle(input int limit);
    int c;
    c = 0;
    while (Busy !== 1'b0 && c < limit) begin
      @(negedge CLK);
      c++;
    end
  endtask

  typedef struct packed {
    logic        mw;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] exp_rd;
    logic        exp_busy;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // Decode vectors applied from idle with an empty FIFO; only the last one pushes.
    vecs[0] = '{1'b1, 32'h1008, 32'h0000_0077, 32'h1008, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h1000, 32'h0000_0055, 32'h1004, 32'h2, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h1004, 32'h0000_0077, 32'h1004, 32'h2, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h0000, 32'h0000_00AA, 32'h0000, 32'h0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h1001, 32'h0000_00AA, 32'h1000, 32'h0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h2000, 32'h0000_00AA, 32'h2004, 32'h0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'h1000, 32'hFFFF_FF3C, 32'h1004, 32'h0, 1'b1, 1'b0};

    RST       = 1'b1;
    ALUResult = '0;
    WriteData = '0;
    MemWrite  = 1'b0;
    RdAddr    = 32'h1004;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_ovf", 32'(Overflow), 32'd0);
    check("rst_status", RdData, 32'h2);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Single frame 0x55 with exact timing
    rx_q.delete();
    set_store(32'h1000, 32'h55);
    @(negedge CLK);
    MemWrite = 1'b0;
    check("a_pre_tx", 32'(TX), 32'd1);
    check("a_pre_busy", 32'(Busy), 32'd1);
    check("a_pre_status", RdData, 32'h0);
    expect_frame(8'h55, "a_frame");
    check("a_busy_last", 32'(Busy), 32'd1);
    @(negedge CLK);
    check("a_busy_end", 32'(Busy), 32'd0);
    check("a_tx_end", 32'(TX), 32'd1);
    check("a_rx", 32'(rx_q.size() > 0 ? rx_q[0] : 9'h1FF), 32'h055);

    // Back-to-back frames with no idle gap
    repeat (3) @(negedge CLK);
    rx_q.delete();
    set_store(32'h1000, 32'hA3);
    @(negedge CLK);
    set_store(32'h1000, 32'h0F);
    expect_frame(8'hA3, "b_frame0");
    expect_frame(8'h0F, "b_frame1");
    @(negedge CLK);
    check("b_busy_end", 32'(Busy), 32'd0);

    // Overflow: six stores in consecutive cycles, the sixth is dropped
    repeat (3) @(negedge CLK);
    rx_q.delete();
    for (int i = 0; i < 6; i++) begin
      set_store(32'h1000, 32'(8'h11 + i));
      @(negedge CLK);
    end
    MemWrite = 1'b0;
    check("c_ovf", 32'(Overflow), 32'd1);
    check("c_status", RdData, 32'hD);
    @(negedge CLK);
    set_store(32'h1004, 32'h8);
    @(negedge CLK);
    MemWrite = 1'b0;
    check("c_ovf_clr", 32'(Overflow), 32'd0);
    check("c_status_clr", RdData, 32'h5);
    wait_rx(5, 400);
    wait_idle(200);
    repeat (5) @(negedge CLK);
    check("c_rx_count", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("c_rx%0d", i), 32'(rx_q.size() > i ? rx_q[i] : 9'h1FF), 32'(8'h11 + i));
    end

    // Table-driven decode vectors
    rx_q.delete();
    for (int i = 0; i < 7; i++) begin
      @(negedge CLK);
      MemWrite  = vecs[i].mw;
      ALUResult = vecs[i].alu;
      WriteData = vecs[i].wd;
      RdAddr    = vecs[i].rd;
      @(negedge CLK);
      MemWrite = 1'b0;
      check($sformatf("v%0d_rd", i), RdData, vecs[i].exp_rd);
      check($sformatf("v%0d_busy", i), 32'(Busy), 32'(vecs[i].exp_busy));
      check($sformatf("v%0d_ovf", i), 32'(Overflow), 32'(vecs[i].exp_ovf));
    end
    RdAddr = 32'h1004;
    wait_rx(1, 100);
    wait_idle(100);
    repeat (5) @(negedge CLK);
    check("v_rx_count", 32'(rx_q.size()), 32'd1);
    check("v_rx0", 32'(rx_q.size() > 0 ? rx_q[0] : 9'h1FF), 32'h03C);

    // Reset mid-frame aborts immediately
    rx_q.delete();
    set_store(32'h1000, 32'h96);
    @(negedge CLK);
    MemWrite = 1'b0;
    repeat (10) @(negedge CLK);
    check("e_busy_pre", 32'(Busy), 32'd1);
    RST = 1'b1;
    #1;
    check("e_tx", 32'(TX), 32'd1);
    check("e_busy", 32'(Busy), 32'd0);
    check("e_status", RdData, 32'h2);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("e_rx_none", 32'(rx_q.size()), 32'd0);
    @(negedge CLK);
    set_store(32'h1000, 32'hC5);
    @(negedge CLK);
    MemWrite = 1'b0;
    wait_rx(1, 100);
    check("e_rx_after", 32'(rx_q.size() > 0 ? rx_q[0] : 9'h1FF), 32'h0C5);
    wait_idle(100);

    // Push into a full FIFO in the same cycle the FSM pops
    repeat (3) @(negedge CLK);
    rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      set_store(32'h1000, 32'(8'h21 + i));
      @(negedge CLK);
    end
    MemWrite = 1'b0;
    check("f_full", RdData, 32'h5);
    repeat (36) @(negedge CLK);
    check("f_full_prepop", RdData, 32'h5);
    set_store(32'h1000, 32'h26);
    @(negedge CLK);
    MemWrite = 1'b0;
    check("f_ovf", 32'(Overflow), 32'd0);
    check("f_status", RdData, 32'h5);
    wait_rx(6, 400);
    check("f_rx_count", 32'(rx_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("f_rx%0d", i), 32'(rx_q.size() > i ? rx_q[i] : 9'h1FF), 32'(8'h21 + i));
    end
    wait_idle(100);
    check("f_idle", 32'(Busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
